// File: rtl/ro_fine_tune_ctrl.sv
// ro_fine_tune_ctrl
//   Closed-loop calibration of a ring oscillator's fine-delay stages. The
//   controller counts synchronised rising edges of roIn over a fixed window of
//   clk cycles and compares the count with a latched target. It then steps a
//   global delay code up (more delay) or down (less delay) until the count is
//   within TOL. The code is spread thermometer-style across NUM_STAGES 2-bit
//   fcSelect fields.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; starts calibration from the current code
//   roIn       ring oscillator output, asynchronous to clk
//   target     desired edges per window, latched on an accepted start
//   fcSelect   per-stage select; stage i occupies bits [2i+1:2i]
//   code       current global fine-delay code (0 .. 3*NUM_STAGES)
//   lastCount  edge count of the most recent completed window
//   busy       calibration in progress
//   locked     holding a code within tolerance
//   fail       calibration aborted (code bound or iteration limit)
//
// Build option
//   RO_FINE_TUNE_TRACK_EN : when defined, the LOCKED state keeps re-measuring
//   and corrects drift by single steps. There is no iteration limit in that
//   mode, and only the code bounds can cause fail.

module ro_fine_tune_ctrl #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned SETTLE     = 16,
  parameter int unsigned TOL        = 2,
  parameter int unsigned MAX_ITER   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    roIn,
  input  logic [CNT_W-1:0]        target,
  output logic [2*NUM_STAGES-1:0] fcSelect,
  output logic [CODE_W-1:0]       code,
  output logic [CNT_W-1:0]        lastCount,
  output logic                    busy,
  output logic                    locked,
  output logic                    fail
);

`ifdef RO_FINE_TUNE_TRACK_EN
  localparam bit TRACK_EN = 1'b1;
`else
  localparam bit TRACK_EN = 1'b0;
`endif

  localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned ITER_W  = $clog2(MAX_ITER + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(3 * NUM_STAGES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t                  state_q;
  logic [2:0]              sync_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [CNT_W-1:0]        edge_cnt_q;
  logic [CNT_W-1:0]        last_cnt_q;
  logic [CNT_W-1:0]        target_q;
  logic [ITER_W-1:0]       iter_q;
  logic [CODE_W-1:0]       code_q;
  logic [2*NUM_STAGES-1:0] fc_q;
  logic                    busy_q;
  logic                    locked_q;
  logic                    fail_q;
  logic                    prev_valid_q;
  logic                    prev_up_q;
  logic                    track_q;

  // Thermometer spread: stage i = clamp(code - 3i, 0, 3).
  function automatic logic [2*NUM_STAGES-1:0] therm(input logic [CODE_W-1:0] c);
    logic [2*NUM_STAGES-1:0] f;
    int unsigned cv;
    int unsigned base;
    f  = '0;
    cv = 32'(c);
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      base = 3 * i;
      if (cv >= base + 3)
        f[2*i +: 2] = 2'd3;
      else if (cv > base)
        f[2*i +: 2] = 2'(cv - base);
    end
    return f;
  endfunction

  // Rising edge of the synchronised oscillator: sync high and delayed low.
  logic rise;
  assign rise = sync_q[1] & ~sync_q[2];

  logic [CNT_W-1:0] edge_cnt_nxt;
  always_comb begin
    edge_cnt_nxt = edge_cnt_q;
    if (rise && (edge_cnt_q != '1))
      edge_cnt_nxt = edge_cnt_q + CNT_W'(1);
  end

  // Comparisons are made one bit wider so target+TOL cannot wrap.
  logic [CNT_W:0] cnt_x, tgt_x, tol_x;
  logic           too_fast, too_slow, reversal, at_bound, iter_limit;
  logic [ITER_W-1:0] iter_nxt;
  logic [CODE_W-1:0] code_adj;

  always_comb begin
    cnt_x      = {1'b0, last_cnt_q};
    tgt_x      = {1'b0, target_q};
    tol_x      = (CNT_W+1)'(TOL);
    too_fast   = cnt_x > (tgt_x + tol_x);
    too_slow   = (cnt_x + tol_x) < tgt_x;
    reversal   = prev_valid_q && ((too_fast && !prev_up_q) || (too_slow && prev_up_q));
    at_bound   = (too_fast && (code_q == CODE_MAX)) || (too_slow && (code_q == '0));
    iter_nxt   = iter_q + ITER_W'(1);
    iter_limit = (iter_nxt == ITER_W'(MAX_ITER));
    code_adj   = too_fast ? (code_q + CODE_W'(1)) : (code_q - CODE_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      tmr_q        <= '0;
      edge_cnt_q   <= '0;
      last_cnt_q   <= '0;
      target_q     <= '0;
      iter_q       <= '0;
      code_q       <= '0;
      fc_q         <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_up_q    <= 1'b0;
      track_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], roIn};
      // Any state with busy low accepts start (IDLE, LOCKED, FAIL and the
      // tracking loop); the code is kept as the starting point.
      if (start && !busy_q) begin
        target_q     <= target;
        iter_q       <= '0;
        locked_q     <= 1'b0;
        fail_q       <= 1'b0;
        busy_q       <= 1'b1;
        tmr_q        <= '0;
        prev_valid_q <= 1'b0;
        track_q      <= 1'b0;
        state_q      <= S_SETTLE;
      end else begin
        case (state_q)
          S_SETTLE: begin
            edge_cnt_q <= '0;
            if (tmr_q == TMR_W'(SETTLE - 1)) begin
              tmr_q   <= '0;
              state_q <= S_MEASURE;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          S_MEASURE: begin
            if (tmr_q == TMR_W'(WINDOW - 1)) begin
              last_cnt_q <= edge_cnt_nxt;
              tmr_q      <= '0;
              state_q    <= S_EVAL;
            end else begin
              edge_cnt_q <= edge_cnt_nxt;
              tmr_q      <= tmr_q + TMR_W'(1);
            end
          end
          S_EVAL: begin
            if (!track_q)
              iter_q <= iter_nxt;
            if ((!too_fast && !too_slow) || reversal) begin
              // A reversed adjust means the target lies between two codes;
              // settle on the current one. Direction history restarts here so
              // a later tracking correction is not mistaken for oscillation.
              locked_q     <= 1'b1;
              busy_q       <= 1'b0;
              prev_valid_q <= 1'b0;
              track_q      <= TRACK_EN;
              state_q      <= S_LOCKED;
            end else if (at_bound || (!track_q && iter_limit)) begin
              fail_q   <= 1'b1;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
              state_q  <= S_FAIL;
            end else begin
              code_q       <= code_adj;
              fc_q         <= therm(code_adj);
              prev_valid_q <= 1'b1;
              prev_up_q    <= too_fast;
              locked_q     <= 1'b0;
              busy_q       <= 1'b1;
              tmr_q        <= '0;
              state_q      <= S_SETTLE;
            end
          end
          S_LOCKED: begin
            if (TRACK_EN) begin
              edge_cnt_q <= '0;
              tmr_q      <= '0;
              state_q    <= S_MEASURE;
            end
          end
          default: begin
            // IDLE and FAIL hold until an accepted start.
          end
        endcase
      end
    end
  end

  assign fcSelect  = fc_q;
  assign code      = code_q;
  assign lastCount = last_cnt_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_ro_fine_tune_ctrl.sv
// Bench for ro_fine_tune_ctrl. A behavioural ring oscillator runs with a period
// of 24+4*code time units (or a fixed 30), which keeps both phases wider than
// one clk period (10 units). Expected outcomes are hand-derived from
// count = 10240/period per 1024-cycle window.
module tb_ro_fine_tune_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        roIn;
  logic [11:0] target;
  logic [7:0]  fcSelect;
  logic [3:0]  code;
  logic [11:0] lastCount;
  logic        busy;
  logic        locked;
  logic        fail;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  bit  ro_fixed  = 1'b0;
  real ro_offset = 0.0;

  ro_fine_tune_ctrl #(
    .NUM_STAGES(4),
    .CODE_W    (4),
    .CNT_W     (12),
    .WINDOW    (1024),
    .SETTLE    (16),
    .TOL       (2),
    .MAX_ITER  (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .roIn     (roIn),
    .target   (target),
    .fcSelect (fcSelect),
    .code     (code),
    .lastCount(lastCount),
    .busy     (busy),
    .locked   (locked),
    .fail     (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin : ro_model
    real half;
    half = ro_fixed ? 15.0 : (24.0 + 4.0 * real'(code) + ro_offset) / 2.0;
    roIn = 1'b1;
    #(half);
    roIn = 1'b0;
    #(half);
  end

  typedef struct {
    logic [11:0] tgt;
    bit          fixed;
    bit          reset_first;
    bit          extra_start;
    logic [3:0]  exp_code;
    logic        exp_locked;
    logic        exp_fail;
    logic [7:0]  exp_fc;
    int unsigned cnt_lo;
    int unsigned cnt_hi;
  } vec_t;

  vec_t vecs[5];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_true(input string name, input bit ok);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0 expected 1", name);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [11:0] tgt);
    @(posedge clk);
    #1;
    target = tgt;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit   ok;
    vec_t e;

    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;

    // Vectors run in order; each starts from the code the previous one left.
    vecs[0] = '{tgt:12'd2000, fixed:1'b0, reset_first:1'b0, extra_start:1'b0,
                exp_code:4'd0,  exp_locked:1'b0, exp_fail:1'b1, exp_fc:8'h00, cnt_lo:426, cnt_hi:427};
    vecs[1] = '{tgt:12'd213,  fixed:1'b0, reset_first:1'b0, extra_start:1'b1,
                exp_code:4'd6,  exp_locked:1'b1, exp_fail:1'b0, exp_fc:8'h0F, cnt_lo:213, cnt_hi:214};
    vecs[2] = '{tgt:12'd171,  fixed:1'b0, reset_first:1'b0, extra_start:1'b0,
                exp_code:4'd9,  exp_locked:1'b1, exp_fail:1'b0, exp_fc:8'h3F, cnt_lo:170, cnt_hi:171};
    vecs[3] = '{tgt:12'd10,   fixed:1'b1, reset_first:1'b1, extra_start:1'b0,
                exp_code:4'd12, exp_locked:1'b0, exp_fail:1'b1, exp_fc:8'hFF, cnt_lo:341, cnt_hi:342};
    vecs[4] = '{tgt:12'd213,  fixed:1'b0, reset_first:1'b0, extra_start:1'b0,
                exp_code:4'd6,  exp_locked:1'b1, exp_fail:1'b0, exp_fc:8'h0F, cnt_lo:213, cnt_hi:214};

    repeat (3) @(posedge clk);
    #1;
    check("rst_code", 32'(code), 32'd0);
    check("rst_fc", 32'(fcSelect), 32'd0);
    check("rst_lastCount", 32'(lastCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].reset_first) do_reset();
      ro_fixed = vecs[i].fixed;
      pulse_start(vecs[i].tgt);
      sb.push_back(vecs[i]);
      check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
      if (vecs[i].extra_start) begin
        // Must be ignored: a restart with 171 would end at code 9.
        repeat (50) @(posedge clk);
        #1;
        target = 12'd171;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check($sformatf("v%0d_busy_after_restart", i), 32'(busy), 32'd1);
        check($sformatf("v%0d_code_after_restart", i), 32'(code), 32'd0);
      end
      wait_idle(40000, ok);
      check_true($sformatf("v%0d_idle_timeout", i), ok);
      e = sb.pop_front();
      check($sformatf("v%0d_code", i), 32'(code), 32'(e.exp_code));
      check($sformatf("v%0d_locked", i), 32'(locked), 32'(e.exp_locked));
      check($sformatf("v%0d_fail", i), 32'(fail), 32'(e.exp_fail));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_fc", i), 32'(fcSelect), 32'(e.exp_fc));
      check_range($sformatf("v%0d_lastCount", i), 32'(lastCount), e.cnt_lo, e.cnt_hi);
    end

    // Drift after lock at code 6: period 52 gives ~197 edges, out of tolerance.
    ro_offset = 4.0;
`ifdef RO_FINE_TUNE_TRACK_EN
    ok = 1'b0;
    for (int unsigned n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (!locked) begin ok = 1'b1; break; end
    end
    check_true("track_unlock_timeout", ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (locked) begin ok = 1'b1; break; end
    end
    check_true("track_relock_timeout", ok);
    check("track_code", 32'(code), 32'd5);
    check("track_fc", 32'(fcSelect), 32'h0B);
    check("track_busy", 32'(busy), 32'd0);
    check("track_fail", 32'(fail), 32'd0);
`else
    repeat (4000) @(posedge clk);
    #1;
    check("static_code", 32'(code), 32'd6);
    check("static_locked", 32'(locked), 32'd1);
    check("static_busy", 32'(busy), 32'd0);
    check("static_fc", 32'(fcSelect), 32'h0F);
`endif

    // Asynchronous reset in the middle of a MEASURE window at code 5.
    ro_offset = 0.0;
    do_reset();
    pulse_start(12'd213);
    ok = 1'b0;
    for (int unsigned n = 0; n < 20000; n++) begin
      @(posedge clk);
      #1;
      if (code == 4'd5) begin ok = 1'b1; break; end
    end
    check_true("mid_reach_code5_timeout", ok);
    repeat (16 + 300) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_code", 32'(code), 32'd0);
    check("mid_rst_fc", 32'(fcSelect), 32'd0);
    check("mid_rst_lastCount", 32'(lastCount), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_fail", 32'(fail), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start(12'd213);
    ok = 1'b0;
    for (int unsigned n = 0; n < 5000; n++) begin
      @(posedge clk);
      #1;
      if (code != 4'd0) begin ok = 1'b1; break; end
    end
    check_true("rerun_first_step_timeout", ok);
    check("rerun_first_step", 32'(code), 32'd1);
    wait_idle(40000, ok);
    check_true("rerun_idle_timeout", ok);
    check("rerun_code", 32'(code), 32'd6);
    check("rerun_locked", 32'(locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
